cpu_result_checker: RTL and testbench

- Self-checking monitor downstream of the single-cycle cpu; consumes its PC and register-file writeback stream.
- Tracks the value of one selected architectural register and detects program halt (PC parked on a jump-to-self).
- Compares the tracked value against an expected answer and raises done/passed/timeout. Benches then read a verdict instead of waiting a fixed delay and peeking into internal registers.

---
 rtl/cpu_result_checker.sv | 99 +++++++++
 tb/tb_cpu_result_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_checker.sv
// Watches the cpu writeback stream, shadows one architectural register and
// reports a pass/fail/timeout verdict once the PC parks on a jump-to-self.
module cpu_result_checker #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int STABLE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  check_reg,
  input  logic [31:0] expected,
  input  logic [31:0] pc,
  input  logic        reg_we,
  input  logic [4:0]  reg_waddr,
  input  logic [31:0] reg_wdata,
  output logic        busy,
  output logic        done,
  output logic        passed,
  output logic        timeout,
  output logic [31:0] observed,
  output logic [31:0] cycle_count,
  output logic [15:0] write_count
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [31:0] exp_val;
  logic [31:0] prev_pc;
  logic [31:0] stable_cnt;

  logic accept, same_pc, halt, tmo, track;

  assign accept  = start && (state == IDLE || state == DONE);
  assign same_pc = (pc == prev_pc);
  assign halt    = same_pc && (stable_cnt == 32'(STABLE_CYCLES - 1));
  assign tmo     = (cycle_count == 32'(TIMEOUT_CYCLES - 1));
  assign track   = reg_we && (reg_waddr == idx) && (idx != 5'd0);

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt) state_nxt = CHECK;
               else if (tmo) state_nxt = DONE;
      CHECK:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      exp_val     <= '0;
      prev_pc     <= '0;
      stable_cnt  <= '0;
      observed    <= '0;
      cycle_count <= '0;
      write_count <= '0;
      passed      <= 1'b0;
      timeout     <= 1'b0;
    end else if (accept) begin
      // verdict bits are left alone so the previous result stays readable
      idx         <= check_reg;
      exp_val     <= expected;
      prev_pc     <= pc;
      stable_cnt  <= '0;
      observed    <= '0;
      cycle_count <= '0;
      write_count <= '0;
    end else if (state == RUN) begin
      cycle_count <= cycle_count + 32'd1;
      prev_pc     <= pc;
      stable_cnt  <= same_pc ? stable_cnt + 32'd1 : 32'd0;
      if (track) begin
        observed <= reg_wdata;
        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      end
      if (tmo && !halt) begin
        timeout <= 1'b1;
        passed  <= 1'b0;
      end
    end else if (state == CHECK) begin
      passed  <= (observed == exp_val);
      timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench for cpu_result_checker: pass, mismatch, $0 tracking,
// halt-cycle write, timeout, re-arm from DONE and mid-run reset.
module tb_cpu_result_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  check_reg = '0;
  logic [31:0] expected = '0;
  logic [31:0] pc = '0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic [31:0] reg_wdata = '0;
  logic        busy, done, passed, timeout;
  logic [31:0] observed, cycle_count;
  logic [15:0] write_count;

  int tests = 0;
  int fails = 0;

  cpu_result_checker #(.TIMEOUT_CYCLES(50), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .check_reg(check_reg),
    .expected(expected), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .busy(busy), .done(done), .passed(passed),
    .timeout(timeout), .observed(observed), .cycle_count(cycle_count),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] p, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    pc = p; reg_we = we; reg_waddr = wa; reg_wdata = wd;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [4:0] r, input logic [31:0] e,
                          input logic [31:0] p);
    start = 1'b1; check_reg = r; expected = e;
    step(p, 1'b0, 5'd0, 32'd0);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    reg_we = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if ({busy, done, passed, timeout} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, passed, timeout});
    end
    tests++;
    if (observed !== 32'd0 || cycle_count !== 32'd0 || write_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_counts: obs=%0d cyc=%0d wc=%0d required 0", observed, cycle_count, write_count);
    end
  endtask

  task automatic test_pass;
    int n;
    do_start(5'd2, 32'd270, 32'd0);
    step(32'd4, 1'b1, 5'd2, 32'd5);
    step(32'd8, 1'b0, 5'd0, 32'd0);
    step(32'd12, 1'b1, 5'd2, 32'd270);
    // start while running must not retarget tracking to $3
    start = 1'b1; check_reg = 5'd3;
    step(32'd16, 1'b1, 5'd3, 32'd1);
    start = 1'b0;
    step(32'h40, 1'b0, 5'd0, 32'd0);
    wait_done(n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL pass_latency: got %0d cycles required 5", n);
    end
    tests++;
    if (passed !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL pass_verdict: passed=%b timeout=%b busy=%b required 1 0 0", passed, timeout, busy);
    end
    tests++;
    if (observed !== 32'd270 || write_count !== 16'd2) begin
      fails++;
      $display("FAIL pass_obs: obs=%0d wc=%0d required 270 2", observed, write_count);
    end
  endtask

  task automatic test_mismatch;
    int n;
    do_start(5'd8, 32'd119, 32'd0);
    step(32'd4, 1'b1, 5'd8, 32'd50);
    step(32'd8, 1'b1, 5'd8, 32'd118);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    wait_done(n);
    tests++;
    if (passed !== 1'b0 || timeout !== 1'b0 || observed !== 32'd118) begin
      fails++;
      $display("FAIL mismatch: passed=%b timeout=%b obs=%0d required 0 0 118", passed, timeout, observed);
    end
  endtask

  task automatic test_reg0;
    int n;
    do_start(5'd0, 32'd0, 32'd0);
    step(32'd4, 1'b1, 5'd0, 32'hFFFF);
    step(32'd8, 1'b1, 5'd3, 32'd9);
    step(32'h30, 1'b0, 5'd0, 32'd0);
    wait_done(n);
    tests++;
    if (observed !== 32'd0 || write_count !== 16'd0 || passed !== 1'b1) begin
      fails++;
      $display("FAIL reg0: obs=%0d wc=%0d passed=%b required 0 0 1", observed, write_count, passed);
    end
  endtask

  task automatic test_halt_write;
    do_start(5'd5, 32'd77, 32'h100);
    step(32'h104, 1'b1, 5'd5, 32'd10);
    step(32'h108, 1'b0, 5'd0, 32'd0);
    step(32'h10C, 1'b0, 5'd0, 32'd0);
    repeat (3) step(32'h10C, 1'b0, 5'd0, 32'd0);
    step(32'h10C, 1'b1, 5'd5, 32'd77);   // halting cycle
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL halt_check_state: busy=%b done=%b required 1 0", busy, done);
    end
    step(32'h10C, 1'b1, 5'd5, 32'd99);   // CHECK cycle, ignored
    tests++;
    if (done !== 1'b1 || passed !== 1'b1 || observed !== 32'd77 || write_count !== 16'd2) begin
      fails++;
      $display("FAIL halt_write: done=%b passed=%b obs=%0d wc=%0d required 1 1 77 2", done, passed, observed, write_count);
    end
  endtask

  task automatic test_timeout;
    int steps;
    logic [31:0] p;
    do_start(5'd1, 32'd0, 32'd0);
    steps = 0;
    p = 32'd0;
    while (!done && steps < 200) begin
      p = p + 32'd4;
      step(p, 1'b0, 5'd0, 32'd0);
      steps++;
    end
    tests++;
    if (done !== 1'b1 || steps !== 50) begin
      fails++;
      $display("FAIL timeout_len: done=%b steps=%0d required 1 50", done, steps);
    end
    tests++;
    if (timeout !== 1'b1 || passed !== 1'b0 || cycle_count !== 32'd50) begin
      fails++;
      $display("FAIL timeout_verdict: timeout=%b passed=%b cyc=%0d required 1 0 50", timeout, passed, cycle_count);
    end
  endtask

  task automatic test_rearm_and_reset;
    do_start(5'd4, 32'd3, 32'h200);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd0 ||
        write_count !== 16'd0 || observed !== 32'd0 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL rearm: busy=%b done=%b cyc=%0d wc=%0d obs=%0d timeout=%b required 1 0 0 0 0 1",
               busy, done, cycle_count, write_count, observed, timeout);
    end
    step(32'h204, 1'b1, 5'd4, 32'd3);
    step(32'h208, 1'b0, 5'd0, 32'd0);
    tests++;
    if (observed !== 32'd3 || cycle_count !== 32'd2) begin
      fails++;
      $display("FAIL rearm_run: obs=%0d cyc=%0d required 3 2", observed, cycle_count);
    end
    reset = 1'b1;
    step(32'h208, 1'b1, 5'd4, 32'd7);
    reset = 1'b0;
    tests++;
    if ({busy, done, passed, timeout} !== 4'b0000 || observed !== 32'd0 ||
        cycle_count !== 32'd0 || write_count !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset: flags=%b obs=%0d cyc=%0d wc=%0d required 0000 0 0 0",
               {busy, done, passed, timeout}, observed, cycle_count, write_count);
    end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_mismatch;
    test_reg0;
    test_halt_write;
    test_timeout;
    test_rearm_and_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
